n64_poll_ctrl: RTL
==================

# n64_poll_ctrl

Polling scheduler for the N64 controller receiver. It replaces the free-running "go" counter in the top level. It issues poll requests at a fixed period and supervises each transaction with a response timeout and bounded retries. It also latches the last good controller word and presents it, with a one-cycle valid strobe, to the SPI slave and LED logic.

## Interface
Parameters:
- POLL_PERIOD, 300_000: clk cycles between scheduled polls (≥ 2·TIMEOUT).
- TIMEOUT, 20_000: clk cycles to wait for the receiver's data_valid after go.
- MAX_RETRY, 2: extra attempts after a timeout before declaring the controller absent.

Ports:
- clk, in, 1: system clock (CLK_33 domain). Single clock.
- reset_n, in, 1: asynchronous, active-low reset.
- enable, in, 1: allows scheduled polling.
- go, out, 1: one-cycle start pulse to the N64 receiver.
- rx_valid, in, 1: data_valid from the N64 receiver.
- rx_data, in, 32: data_out from the N64 receiver.
- data_out, out, 32: last successfully received word.
- data_valid, out, 1: one-cycle strobe when data_out updates.
- present, out, 1: controller answered the most recent poll sequence.
- timeout_cnt, out, 16: saturating count of failed poll sequences.
- busy, out, 1: a transaction is in progress (state ≠ IDLE).

## Operation
- Reset values:
  - All outputs are 0.
  - The period counter, retry counter, wait timer and pending flag are 0.
  - State is IDLE.
- Period counter:
  - Counts 0..POLL_PERIOD-1 while enable=1. Held at 0 while enable=0.
  - At the terminal count, pending is set.
  - A tick that arrives while pending is already set is dropped; overruns are not queued.
- States:
  - IDLE: if pending and enable, go to START, clear pending and clear the retry counter.
  - START: go=1 for this cycle only. Clear the wait timer. Go to WAIT.
  - WAIT: increment the timer each cycle.
    - If rx_valid=1, go to DONE. This has priority even if the timer is at TIMEOUT-1 in the same cycle.
    - Else if timer=TIMEOUT-1:
      - If retry < MAX_RETRY: increment retry, go to START.
      - Otherwise go to FAIL.
  - DONE: data_out←rx_data (captured in the WAIT→DONE edge), data_valid=1, present←1. Go to IDLE.
  - FAIL: present←0, timeout_cnt←timeout_cnt+1 (saturating at 0xFFFF). data_out is unchanged. Go to IDLE.
- rx_valid outside WAIT is ignored.
- enable=0 mid-transaction:
  - The current sequence, including retries, completes normally because the receiver is already driving the line.
  - No new go is issued afterwards.
- Async reset mid-transaction: all outputs drop to reset values immediately. No go is issued until a fresh period elapses.

## Timing
- go is registered and high for exactly 1 cycle per attempt.
- Scheduled go follows the pending-set cycle by 2 cycles: IDLE→START, then go.
- On timeout, go-to-retry-go spacing is TIMEOUT+1 cycles.
- data_valid is high the cycle after rx_valid is sampled in WAIT, and data_out is valid in that same cycle. Latency is 1 cycle.
- present and timeout_cnt update on the same edge as data_valid (DONE) or on entry to IDLE from FAIL.
- Worst-case sequence length is (MAX_RETRY+1)·(TIMEOUT+1)+2 cycles, which must be < POLL_PERIOD.

## Structure
- Shared package n64_pkg:
  - state enum {IDLE, START, WAIT, DONE, FAIL}.
  - N64_WORD_W=32.
  - TIMEOUT_CNT_W=16.
- One sub-module, poll_tick_gen, holds the period counter with enable and produces the terminal-count pulse. The FSM, timer, retry counter and output registers stay in n64_poll_ctrl.

## Test plan
Bench parameters: POLL_PERIOD=100, TIMEOUT=20, MAX_RETRY=2.
- Reset and periodic polling: hold reset_n=0, then release with enable=1 and no rx_valid stimulus → all outputs 0 during reset. The first go appears 2 cycles after the first terminal count.
- Normal response: rx_valid with rx_data=0xA5A5_0001 5 cycles after go → data_out=0xA5A5_0001 and data_valid pulses for 1 cycle on the next edge. present=1, busy=0 one cycle later, and the next go comes 100 cycles after the previous scheduled go.
- No response: → 3 go pulses spaced 21 cycles apart, then timeout_cnt=1 and present=0. data_out keeps its prior value and data_valid never pulses.
- Late success: a response only after the second retry's go with 0x0000_8000 → data_out=0x0000_8000, present=1, timeout_cnt unchanged.
- Priority and ignored strobes:
  - rx_valid on the same cycle as timer=19 on the final attempt → accepted as success, timeout_cnt unchanged.
  - rx_valid while IDLE → ignored.
- Mid-flight controls:
  - Deassert enable during WAIT → the sequence completes and no further go occurs.
  - Assert reset_n=0 during WAIT → go, data_valid, present, busy and timeout_cnt are 0 asynchronously. After release, polling restarts cleanly.

Source files
------------

// File: rtl/n64_pkg.sv
// Shared types and widths for the N64 controller polling logic.
package n64_pkg;

  localparam int N64_WORD_W    = 32;
  localparam int TIMEOUT_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    DONE,
    FAIL
  } state_t;

endpackage

// File: rtl/n64_poll_ctrl_tick_gen.sv
// Poll period counter: one-cycle tick at the terminal count, held at zero while
// polling is disabled so a re-enable always starts a full fresh period.
module poll_tick_gen #(
  parameter int PERIOD = 300_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CNT_W-1:0] cnt_reg;

  assign tick = enable && (cnt_reg == CNT_W'(PERIOD - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (!enable || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/n64_poll_ctrl.sv
// Poll scheduler for the N64 receiver: periodic go pulses, response timeout with
// bounded retries, and a latched copy of the last good controller word.
module n64_poll_ctrl
  import n64_pkg::*;
#(
  parameter int POLL_PERIOD = 300_000,
  parameter int TIMEOUT     = 20_000,
  parameter int MAX_RETRY   = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  output logic                     go,
  input  logic                     rx_valid,
  input  logic [N64_WORD_W-1:0]    rx_data,
  output logic [N64_WORD_W-1:0]    data_out,
  output logic                     data_valid,
  output logic                     present,
  output logic [TIMEOUT_CNT_W-1:0] timeout_cnt,
  output logic                     busy
);

  localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

  state_t                     state_reg, state_next;
  logic                       tick;
  logic                       pending_reg;
  logic [TIMER_W-1:0]         timer_reg;
  logic [RETRY_W-1:0]         retry_reg;
  logic                       go_reg;
  logic                       data_valid_reg;
  logic                       present_reg;
  logic [N64_WORD_W-1:0]      data_out_reg;
  logic [TIMEOUT_CNT_W-1:0]   timeout_cnt_reg;
  logic                       attempt_expired;

  poll_tick_gen #(
    .PERIOD(POLL_PERIOD)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable),
    .tick   (tick)
  );

  // A response in the last timer cycle still wins over the timeout.
  assign attempt_expired = (state_reg == WAIT) && !rx_valid && (timer_reg == TIMER_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (pending_reg && enable) state_next = START;
      START: state_next = WAIT;
      WAIT: begin
        if (rx_valid) begin
          state_next = DONE;
        end else if (attempt_expired) begin
          state_next = (retry_reg < RETRY_MAX) ? START : FAIL;
        end
      end
      DONE:    state_next = IDLE;
      FAIL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      pending_reg     <= 1'b0;
      timer_reg       <= '0;
      retry_reg       <= '0;
      go_reg          <= 1'b0;
      data_valid_reg  <= 1'b0;
      present_reg     <= 1'b0;
      data_out_reg    <= '0;
      timeout_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      go_reg         <= (state_next == START);
      data_valid_reg <= (state_next == DONE);

      // Ticks landing while a request is still pending are simply absorbed.
      if (state_reg == IDLE && state_next == START) begin
        pending_reg <= 1'b0;
      end else if (tick) begin
        pending_reg <= 1'b1;
      end

      if (state_reg == IDLE && state_next == START) begin
        retry_reg <= '0;
      end else if (attempt_expired && retry_reg < RETRY_MAX) begin
        retry_reg <= retry_reg + RETRY_W'(1);
      end

      if (state_reg == START) begin
        timer_reg <= '0;
      end else if (state_reg == WAIT) begin
        timer_reg <= timer_reg + TIMER_W'(1);
      end

      if (state_next == DONE) begin
        data_out_reg <= rx_data;
        present_reg  <= 1'b1;
      end

      if (state_reg == FAIL) begin
        present_reg <= 1'b0;
        if (timeout_cnt_reg != '1) begin
          timeout_cnt_reg <= timeout_cnt_reg + TIMEOUT_CNT_W'(1);
        end
      end
    end
  end

  assign go          = go_reg;
  assign data_valid  = data_valid_reg;
  assign present     = present_reg;
  assign data_out    = data_out_reg;
  assign timeout_cnt = timeout_cnt_reg;
  assign busy        = (state_reg != IDLE);

endmodule
